// File: rtl/exc_vector_seq_pkg.sv
// Shared CPU definitions used by the exception vector sequencer, the main
// control unit and the memory address mux.
//   cause_e    : latched exception cause codes
//   exc_state_e: exception sequencer state encoding
//   SEL_*      : memory address mux select codes
//   exc_prio   : fixed-priority resolution of simultaneous requests
package exc_vector_seq_pkg;

  typedef enum logic [1:0] {
    CAUSE_NONE   = 2'b00,
    CAUSE_OPCODE = 2'b01,
    CAUSE_OVF    = 2'b10,
    CAUSE_DIV0   = 2'b11
  } cause_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SAVE = 3'd1,
    ST_WAIT = 3'd2,
    ST_LOAD = 3'd3,
    ST_DONE = 3'd4
  } exc_state_e;

  localparam logic [2:0] SEL_PC   = 3'b000;
  localparam logic [2:0] SEL_V253 = 3'b100;
  localparam logic [2:0] SEL_V254 = 3'b101;
  localparam logic [2:0] SEL_V255 = 3'b110;

  // Opcode beats overflow beats divide-by-zero.
  function automatic cause_e exc_prio(input logic opcode, input logic ovf,
                                      input logic div0);
    if (opcode)    return CAUSE_OPCODE;
    else if (ovf)  return CAUSE_OVF;
    else if (div0) return CAUSE_DIV0;
    else           return CAUSE_NONE;
  endfunction

  // Each cause owns one vector byte in memory; NONE falls back to the PC.
  function automatic logic [2:0] cause_to_sel(input cause_e c);
    case (c)
      CAUSE_OPCODE: return SEL_V253;
      CAUSE_OVF:    return SEL_V254;
      CAUSE_DIV0:   return SEL_V255;
      default:      return SEL_PC;
    endcase
  endfunction

endpackage

// File: rtl/exc_vector_seq.sv
// Exception vector sequencer. On an exception request seen in IDLE it saves
// the faulting PC into EPC, points the memory address mux at the cause's
// vector byte, waits MEM_WAIT cycles for the read, then loads the handler
// byte into the PC.
//
// state | meaning
// IDLE  | waiting for a request, mux on PC
// SAVE  | one-cycle EPC write, vector address driven
// WAIT  | memory read in flight, counter runs to MEM_WAIT-1
// LOAD  | one-cycle PC write with the handler address
// DONE  | one-cycle completion pulse, mux back on PC
//
// Ports:
//   clk           system clock, rising edge
//   reset         asynchronous active-low reset
//   exc_opcode    nonexistent-opcode request (level)
//   exc_overflow  arithmetic overflow request (level)
//   exc_div0      divide-by-zero request (level)
//   pc_in         current PC, already advanced by 4
//   mem_rdata     memory read data, handler byte in [7:0]
//   addr_sel      memory address mux select
//   epc_wr/epc_val  EPC write strobe and value
//   pc_wr/pc_val    PC write strobe and handler address
//   cause         latched cause code
//   busy          sequence running, stalls the main control unit
//   done          one-cycle completion pulse
module exc_vector_seq
  import exc_vector_seq_pkg::*;
#(
  parameter int unsigned MEM_WAIT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        exc_opcode,
  input  logic        exc_overflow,
  input  logic        exc_div0,
  input  logic [31:0] pc_in,
  input  logic [31:0] mem_rdata,
  output logic [2:0]  addr_sel,
  output logic        epc_wr,
  output logic [31:0] epc_val,
  output logic        pc_wr,
  output logic [31:0] pc_val,
  output logic [1:0]  cause,
  output logic        busy,
  output logic        done
);

  localparam logic [2:0] WAIT_LAST = 3'(MEM_WAIT - 1);

  exc_state_e  state_q, state_d;
  logic [2:0]  wait_cnt_q;
  cause_e      cause_q;
  logic [31:0] epc_q;
  logic [31:0] pc_q;
  logic        any_req;
  logic        wait_last;

  // Only the handler byte is architecturally meaningful.
  logic unused_rdata_hi;
  assign unused_rdata_hi = ^mem_rdata[31:8];

  assign any_req   = exc_opcode | exc_overflow | exc_div0;
  assign wait_last = (wait_cnt_q == WAIT_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    addr_sel = SEL_PC;
    epc_wr   = 1'b0;
    pc_wr    = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (any_req) state_d = ST_SAVE;
      end
      ST_SAVE: begin
        addr_sel = cause_to_sel(cause_q);
        epc_wr   = 1'b1;
        busy     = 1'b1;
        state_d  = ST_WAIT;
      end
      ST_WAIT: begin
        addr_sel = cause_to_sel(cause_q);
        busy     = 1'b1;
        if (wait_last) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        addr_sel = cause_to_sel(cause_q);
        pc_wr    = 1'b1;
        busy     = 1'b1;
        state_d  = ST_DONE;
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath registers. pc_q captures the read data on the WAIT->LOAD edge
  // so pc_val is already stable for the whole LOAD cycle and then holds.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt_q <= '0;
      cause_q    <= CAUSE_NONE;
      epc_q      <= '0;
      pc_q       <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (any_req) begin
            cause_q <= exc_prio(exc_opcode, exc_overflow, exc_div0);
            epc_q   <= pc_in - 32'd4;
          end
        end
        ST_SAVE: wait_cnt_q <= '0;
        ST_WAIT: begin
          wait_cnt_q <= wait_cnt_q + 3'd1;
          if (wait_last) pc_q <= {24'b0, mem_rdata[7:0]};
        end
        default: ;
      endcase
    end
  end

  assign epc_val = epc_q;
  assign pc_val  = pc_q;
  assign cause   = cause_q;

endmodule

// File: doc/exc_vector_seq.md
EXC_VECTOR_SEQ -- requirements
Module: exc_vector_seq

Interface
REQ-001 Parameter MEM_WAIT, default 2, SHALL be the number of cycles between driving a vector address and memory read data being valid (legal range 1..7).
REQ-002 clk  input  1  system clock; all state changes on the rising edge.
REQ-003 reset  input  1  reset: asynchronous, active-low.
REQ-004 exc_opcode  input  1  nonexistent-opcode exception request (level, sampled in IDLE only).
REQ-005 exc_overflow  input  1  arithmetic overflow exception request.
REQ-006 exc_div0  input  1  divide-by-zero exception request.
REQ-007 pc_in  input  32  current PC, already advanced by 4.
REQ-008 mem_rdata  input  32  memory read data; bits [7:0] hold the handler byte.
REQ-009 addr_sel  output  3  memory-address mux select: 000 = PC, 100 = 253, 101 = 254, 110 = 255.
REQ-010 epc_wr  output  1  one-cycle EPC write strobe.
REQ-011 epc_val  output  32  value to write into EPC.
REQ-012 pc_wr  output  1  one-cycle PC write strobe.
REQ-013 pc_val  output  32  handler address for PC.
REQ-014 cause  output  2  latched cause: 00 none, 01 opcode, 10 overflow, 11 div0.
REQ-015 busy  output  1  high while the sequence runs; the main control unit stalls on it.
REQ-016 done  output  1  one-cycle pulse on sequence completion.

Function
REQ-017 States SHALL be IDLE, SAVE, WAIT, LOAD and DONE.
REQ-018 IDLE: addr_sel=000, busy=0, all strobes 0; any request high moves to SAVE the next edge.
REQ-019 Simultaneous requests SHALL resolve with priority opcode > overflow > div0; only the winner is latched into cause.
REQ-020 On the IDLE->SAVE edge, epc_val SHALL be latched as pc_in - 4 (mod 2^32) and addr_sel set to 100/101/110 for cause 01/10/11.
REQ-021 SAVE: epc_wr=1 for exactly one cycle, busy=1; then WAIT with wait counter cleared.
REQ-022 WAIT: addr_sel held, counter increments each cycle; leaves for LOAD when the counter reaches MEM_WAIT-1.
REQ-023 LOAD: pc_val = {24'b0, mem_rdata[7:0]} and pc_wr=1 for exactly one cycle, addr_sel still held.
REQ-024 DONE: done=1 for one cycle, addr_sel returns to 000, busy=0; next state IDLE.
REQ-025 Latency from request seen in IDLE to pc_wr SHALL be MEM_WAIT+2 cycles.
REQ-026 Requests arriving outside IDLE SHALL be ignored, with no queuing; a request still high in IDLE after DONE starts a new sequence.
REQ-027 cause, epc_val and pc_val SHALL hold their values until the next sequence overwrites them.
REQ-028 pc_in = 0 SHALL produce epc_val = 32'hFFFFFFFC (wrap, no fault).

Reset
REQ-029 Reset asserted at any time, including mid-sequence, SHALL force IDLE with addr_sel=000, cause=00, epc_val=0, pc_val=0, wait counter=0, and epc_wr, pc_wr, busy and done all 0.
REQ-030 A strobe interrupted by reset SHALL not complete; after release the block samples requests on the first rising edge.

Structure
REQ-031 Cause codes, addr_sel codes (SEL_PC, SEL_V253, SEL_V254, SEL_V255) and the state encoding SHALL live in the shared CPU package, common with the control unit and the address mux.
REQ-032 The block SHALL be a single module with no sub-modules; the wait counter stays inline.

Verification
REQ-033 Scenario: exc_overflow=1, pc_in=0x40, MEM_WAIT=2, mem_rdata=0x000000A8 -> addr_sel=101; epc_wr 1 cycle later with epc_val=0x3C; pc_wr with pc_val=0xA8 four cycles after request; cause=10.
REQ-034 Scenario: all three requests high together -> cause=01, addr_sel=100.
REQ-035 Scenario: exc_div0 raised during WAIT of an opcode sequence -> ignored, cause stays 01, a single pc_wr.
REQ-036 Scenario: reset low during WAIT -> outputs immediately at reset values; no pc_wr after release.
REQ-037 Scenario: pc_in=0, exc_opcode=1 -> epc_val=0xFFFFFFFC.
REQ-038 Scenario: MEM_WAIT=5, mem_rdata=0xFFFFFF7E -> pc_wr 7 cycles after request, pc_val=0x0000007E.
